// File: rtl/dma_arb_pkg.sv
// dma_arb_pkg: shared state encoding and constants for the DMA port arbiter
package dma_arb_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;
    localparam int   DMA_DW = 16;
    localparam logic DMA_RD = 1'b1;
    localparam logic DMA_WR = 1'b0;
endpackage

// File: rtl/dma_rr_picker.sv
// dma_rr_picker: first requester found scanning cyclically from ptr+1
module dma_rr_picker #(
    parameter int N_DEV = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_DEV-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_DEV-1:0] winner,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    // Scan from the farthest offset down so the nearest requester is assigned last and wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int k = N_DEV; k >= 1; k--) begin
            sum  = {1'b0, ptr} + (PTR_W+1)'(k);
            sum  = (sum >= (PTR_W+1)'(N_DEV)) ? sum - (PTR_W+1)'(N_DEV) : sum;
            cand = sum[PTR_W-1:0];
            if (req[cand]) begin
                winner       = '0;
                winner[cand] = 1'b1;
                idx          = cand;
                valid        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dma_arbiter.sv
// dma_arbiter: round-robin sharing of one DMA controller port among N_DEV devices
module dma_arbiter
    import dma_arb_pkg::*;
#(
    parameter int N_DEV      = 4,
    parameter int PTR_W      = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_DEV-1:0]        dev_rqst,
    input  logic [N_DEV-1:0]        dev_rd_wr,
    input  logic [DMA_DW*N_DEV-1:0] dev_start_addr,
    input  logic [DMA_DW*N_DEV-1:0] dev_num_words,
    input  logic [DMA_DW*N_DEV-1:0] dev_wdata,
    input  logic [N_DEV-1:0]        dev_ack_in,
    output logic [N_DEV-1:0]        dev_dma_ack,
    output logic [N_DEV-1:0]        dev_end_flag,
    output logic [DMA_DW-1:0]       dev_rdata,
    output logic                    ctl_rqst,
    output logic                    ctl_rd_wr,
    output logic [DMA_DW-1:0]       ctl_start_addr,
    output logic [DMA_DW-1:0]       ctl_num_words,
    output logic [DMA_DW-1:0]       ctl_wdata,
    output logic                    ctl_dev_ack,
    input  logic                    ctl_dma_ack,
    input  logic                    ctl_end_flag,
    input  logic [DMA_DW-1:0]       ctl_rdata,
    output logic [N_DEV-1:0]        grant,
    output logic                    busy
);
    arb_state_t                     state, state_nxt;
    logic [PTR_W-1:0]               owner, rr_ptr, pick_idx;
    logic [N_DEV-1:0]               pick_onehot;
    logic                           pick_valid;
    logic [3:0]                     gap_cnt;
    logic                           gap_done;
    logic [N_DEV-1:0][DMA_DW-1:0]   addr_v, num_v, wdata_v;
    assign addr_v   = dev_start_addr;
    assign num_v    = dev_num_words;
    assign wdata_v  = dev_wdata;
    assign gap_done = gap_cnt == 4'(GAP_CYCLES-1);
    dma_rr_picker #(.N_DEV(N_DEV), .PTR_W(PTR_W)) u_picker (
        .req    (dev_rqst),
        .ptr    (rr_ptr),
        .winner (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = pick_valid ? GRANT : IDLE;
            GRANT:   state_nxt = BUSY;
            BUSY:    state_nxt = (ctl_end_flag || !dev_rqst[owner]) ? RELEASE : BUSY;
            RELEASE: state_nxt = (gap_done && !ctl_end_flag) ? IDLE : RELEASE;
            default: state_nxt = IDLE;
        endcase
    end
    // rr_ptr starts at the last device so device 0 has first priority out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant   <= '0;
            owner   <= '0;
            rr_ptr  <= PTR_W'(N_DEV-1);
            gap_cnt <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                owner <= pick_idx;
                grant <= pick_onehot;
            end
            if (state == RELEASE && state_nxt == IDLE)
                grant <= '0;
            if (state == BUSY && state_nxt == RELEASE)
                rr_ptr <= owner;
            gap_cnt <= (state != RELEASE) ? 4'd0 : gap_done ? gap_cnt : gap_cnt + 4'd1;
        end
    end
    // Controller-side buses are forced to zero outside an ownership window.
    always_comb begin
        busy           = state != IDLE;
        ctl_rqst       = state == BUSY && dev_rqst[owner];
        ctl_rd_wr      = busy ? dev_rd_wr[owner] : DMA_WR;
        ctl_start_addr = busy ? addr_v[owner] : '0;
        ctl_num_words  = busy ? num_v[owner] : '0;
        ctl_wdata      = busy ? wdata_v[owner] : '0;
        ctl_dev_ack    = busy && dev_ack_in[owner];
        dev_dma_ack    = (ctl_dma_ack && state == BUSY) ? grant : '0;
        dev_end_flag   = (ctl_end_flag && (state == BUSY || state == RELEASE)) ? grant : '0;
        dev_rdata      = ctl_rdata;
    end
    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant));
    a_rqst_in_busy: assert property (@(posedge clk) disable iff (!reset_n) ctl_rqst |-> state == BUSY);
endmodule

// File: doc/dma_arbiter.md
Name: dma_arbiter

Overview:
Shares the single DMA controller port between N DMA-capable peripherals, such as simple DMA devices. Each device presents its own request, direction, start address, word count and write data. The arbiter picks one owner with round-robin priority and muxes that owner's signals onto the controller. It routes ack, end flag and read data back to the owner only, and holds ownership until the transfer ends or the owner withdraws its request.

Parameters:
N_DEV, 4, number of requesting devices (2..8)
PTR_W, 2, owner index width, equal to clog2(N_DEV)
GAP_CYCLES, 2, minimum idle cycles with ctl_rqst low between two grants (1..15)

Ports:
clk  input  1  main system clock
reset_n  input  1  reset, asynchronous, active-low
dev_rqst  input  N_DEV  per-device DMA request
dev_rd_wr  input  N_DEV  per-device direction (1 read, 0 write)
dev_start_addr  input  16*N_DEV  packed start addresses, device i at [16i+15:16i]
dev_num_words  input  16*N_DEV  packed word counts
dev_wdata  input  16*N_DEV  packed write data (device dev_out)
dev_ack_in  input  N_DEV  per-device dev_ack
dev_dma_ack  output  N_DEV  controller ack routed to the owner
dev_end_flag  output  N_DEV  controller end flag routed to the owner
dev_rdata  output  16  read data, broadcast to all devices
ctl_rqst  output  1  request to the DMA controller
ctl_rd_wr  output  1  owner direction
ctl_start_addr  output  16  owner start address
ctl_num_words  output  16  owner word count
ctl_wdata  output  16  owner write data
ctl_dev_ack  output  1  owner dev_ack
ctl_dma_ack  input  1  controller ack
ctl_end_flag  input  1  controller end-of-operation
ctl_rdata  input  16  controller read data
grant  output  N_DEV  one-hot current owner (registered)
busy  output  1  high in GRANT, BUSY and RELEASE

Behaviour:
- The clock and reset are fixed: one clock clk; reset_n is asynchronous and active-low.
- States: IDLE, GRANT, BUSY, RELEASE. State, grant, owner index, rr_ptr and gap counter are registered.
- Reset values:
  - State IDLE; grant 0; busy 0; ctl_rqst 0.
  - All ctl_* buses and dev_dma_ack/dev_end_flag are 0. This is forced by gating with the state, not by relying on an idle mux.
  - rr_ptr = N_DEV-1, so device 0 wins first.
- IDLE:
  - If any dev_rqst is high, pick the first requester scanning cyclically from rr_ptr+1 (wrapping at N_DEV-1 to 0).
  - Register it as owner, set grant one-hot, go to GRANT.
- GRANT: one cycle; ctl_rqst stays 0 and the muxed attributes become stable. Go to BUSY.
- BUSY:
  - ctl_rqst = dev_rqst[owner].
  - ctl_rd_wr, ctl_start_addr, ctl_num_words, ctl_wdata and ctl_dev_ack are the owner's signals, combinational mux.
  - Latency from dev_rqst rise to ctl_rqst rise is 2 cycles when the arbiter is idle.
- Routing:
  - dev_dma_ack[i] = ctl_dma_ack & grant[i] & (state==BUSY).
  - dev_end_flag[i] = ctl_end_flag & grant[i], in BUSY or RELEASE.
  - dev_rdata = ctl_rdata, unconditionally.
- BUSY exit:
  - ctl_end_flag high goes to RELEASE.
  - dev_rqst[owner] low (withdrawal or abort) goes to RELEASE.
  - If both occur in the same cycle, there is a single transition to RELEASE.
  - On exit, rr_ptr <= owner.
- RELEASE:
  - ctl_rqst = 0, grant is held, and the gap counter counts from 0.
  - Go to IDLE once the counter reaches GAP_CYCLES-1 and ctl_end_flag is low.
  - If end_flag stays high, wait without bound. On entry to IDLE, grant is cleared.
- Requests arriving in GRANT/BUSY/RELEASE are ignored until IDLE. No request is lost: a device's level request stays pending.
- Fairness: with all devices requesting continuously, grants cycle 0,1,..,N_DEV-1,0.
- Reset mid-operation: all outputs drop immediately (asynchronous); after release the arbiter restarts in IDLE with device 0 highest priority.
- Width rules:
  - Owner index is PTR_W bits; the wrap compares against N_DEV-1 because N_DEV need not be a power of 2.
  - The gap counter is 4 bits.

Decomposition:
- Shared package dma_arb_pkg: state encoding (IDLE=0, GRANT=1, BUSY=2, RELEASE=3), DMA_DW=16, direction constants DMA_RD=1/DMA_WR=0.
- One combinational sub-module, dma_rr_picker: inputs req[N_DEV] and ptr; outputs a one-hot winner, its index and a valid flag. It is reusable by future DMA channel schedulers.
- FSM, muxes and routing live in dma_arbiter.

Test Plan:
- Single read: dev_rqst=4'b0100, dev2 addr 16'h0200, num 3, rd_wr 1.
  - grant=4'b0100 at cycle 1; ctl_rqst=1 at cycle 2; ctl_start_addr=16'h0200; ctl_num_words=3.
  - ctl_dma_ack pulses appear only on dev_dma_ack[2].
  - End flag goes to RELEASE; ctl_rqst low for 2 cycles; then IDLE.
- Contention: dev_rqst=4'b1011 held, each transfer ended by end_flag → grant order 0,1,3,0; never two grants; ctl_rqst low for ≥GAP_CYCLES between owners.
- Withdrawal: dev1 drops dev_rqst mid-BUSY with no end flag → ctl_rqst 0 the same cycle, RELEASE, next owner picked after rr_ptr=1.
- Write path: dev3 rd_wr 0, wdata 16'hBEEF, dev_ack_in[3]=1 → ctl_wdata=16'hBEEF, ctl_dev_ack=1; other devices' dev_ack_in changes do not affect ctl_dev_ack.
- Reset mid-BUSY: reset_n low asynchronously → ctl_rqst, grant, busy 0 without a clock edge; after release with dev_rqst=4'b1111 → grant=4'b0001.
- Simultaneous end_flag and owner rqst drop: a single RELEASE entry; dev_end_flag[owner]=1 for that cycle; no double advance of rr_ptr.
